irq_source_ctrl: RTL and testbench

- Machine-mode interrupt source block: the requester end of the core's `interrupt` line.
- Holds a 64-bit mtime/mtimecmp timer, a software-interrupt bit (MSIP) and NUM_EXT edge-triggered external lines.
- Arbitrates among them and presents one registered request plus its cause code to the exception unit.
- Core software programs it over a simple word-addressed MMIO port. The core returns `irq_ack` in the cycle it takes the trap.

---
 rtl/irq_source_ctrl_pkg.sv | 33 +++
 rtl/irq_source_ctrl_sync_edge.sv | 28 ++
 rtl/irq_source_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_irq_source_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_source_ctrl_pkg.sv
// rtl/irq_source_ctrl_pkg.sv - shared register map, cause codes and request FSM states
package irq_source_ctrl_pkg;

  // Word-aligned register offsets on the MMIO port
  localparam logic [4:0] ADDR_MTIME_LO    = 5'h00;
  localparam logic [4:0] ADDR_MTIME_HI    = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] ADDR_MSIP        = 5'h10;
  localparam logic [4:0] ADDR_EIE         = 5'h14;
  localparam logic [4:0] ADDR_EIP         = 5'h18;

  // mcause values shared with the exception unit
  localparam logic [31:0] CAUSE_NONE = 32'h0000_0000;
  localparam logic [31:0] CAUSE_MSI  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI  = 32'h8000_000B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_e;

  // Fixed priority: external > software > timer
  function automatic logic [31:0] arb_cause(input logic mei, input logic msi, input logic mti);
    if (mei) return CAUSE_MEI;
    if (msi) return CAUSE_MSI;
    if (mti) return CAUSE_MTI;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/irq_source_ctrl_sync_edge.sv
// rtl/irq_source_ctrl_sync_edge.sv - 2-flop synchronizer with rising-edge detect
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two metastability flops, then one flop of history for the edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_source_ctrl.sv
// rtl/irq_source_ctrl.sv - machine-mode timer/software/external interrupt source and requester
module irq_source_ctrl
  import irq_source_ctrl_pkg::*;
#(
  parameter int NUM_EXT  = 4,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         bus_addr,
  input  logic               bus_we,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  input  logic [NUM_EXT-1:0] ext_irq_in,
  output logic               irq_out,
  output logic [31:0]        irq_cause,
  input  logic               irq_ack
);

  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               msip_q, msip_d;
  logic [NUM_EXT-1:0] eie_q, eie_d;
  logic [NUM_EXT-1:0] eip_q, eip_d;
  logic [PW-1:0]      presc_q, presc_d;

  irq_state_e         state_q;
  logic               irq_out_q;
  logic [31:0]        irq_cause_q;
  logic [IDX_W-1:0]   ext_idx_q;

  logic [4:0]         word_addr;
  logic               tick;
  logic               mti;
  logic               mei;
  logic [NUM_EXT-1:0] ext_act;
  logic [NUM_EXT-1:0] ext_rise;
  logic [NUM_EXT-1:0] ack_clr;
  logic [IDX_W-1:0]   win_idx;
  logic [31:0]        win_cause;
  logic               granted_live;

  // Byte address with the sub-word bits dropped
  assign word_addr = bus_addr & 5'b11100;

  // One synchronizer + edge detector per external line
  for (genvar g = 0; g < NUM_EXT; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (ext_irq_in[g]),
      .rise_o  (ext_rise[g])
    );
  end

  assign tick    = (presc_q == PRESC_MAX);
  assign mti     = (mtime_q >= mtimecmp_q);
  assign ext_act = eip_q & eie_q;
  assign mei     = |ext_act;

  // Lowest-indexed enabled pending line wins within MEI
  always_comb begin
    win_idx = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_act[i]) win_idx = IDX_W'(i);
    end
  end

  assign win_cause = arb_cause(mei, msip_q, mti);

  // Whether the source that was granted is still asserting
  always_comb begin
    case (irq_cause_q)
      CAUSE_MEI: granted_live = eip_q[ext_idx_q] & eie_q[ext_idx_q];
      CAUSE_MSI: granted_live = msip_q;
      CAUSE_MTI: granted_live = mti;
      default:   granted_live = 1'b0;
    endcase
  end

  // Ack of an external request retires the latched pending bit
  always_comb begin
    ack_clr = '0;
    if (state_q == ST_REQ && irq_ack && irq_cause_q == CAUSE_MEI) begin
      ack_clr[ext_idx_q] = 1'b1;
    end
  end

  // Register-file next state: bus writes, timer advance, pending set/clear
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    eie_d      = eie_q;
    eip_d      = eip_q & ~ack_clr;
    if (bus_we) begin
      case (word_addr)
        ADDR_MTIME_LO:    mtime_d = {mtime_q[63:32], bus_wdata};
        ADDR_MTIME_HI:    mtime_d = {bus_wdata, mtime_q[31:0]};
        ADDR_MTIMECMP_LO: mtimecmp_d[31:0]  = bus_wdata;
        ADDR_MTIMECMP_HI: mtimecmp_d[63:32] = bus_wdata;
        ADDR_MSIP:        msip_d = bus_wdata[0];
        ADDR_EIE:         eie_d  = bus_wdata[NUM_EXT-1:0];
        ADDR_EIP:         eip_d  = eip_d & ~bus_wdata[NUM_EXT-1:0];
        default:          ;
      endcase
    end
    // A new edge beats any clear in the same cycle
    eip_d = eip_d | ext_rise;
  end

  // Register-file state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      eie_q      <= '0;
      eip_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      eie_q      <= eie_d;
      eip_q      <= eip_d;
    end
  end

  // Request FSM with registered irq_out/irq_cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      irq_out_q   <= 1'b0;
      irq_cause_q <= CAUSE_NONE;
      ext_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_cause != CAUSE_NONE) begin
            irq_out_q   <= 1'b1;
            irq_cause_q <= win_cause;
            ext_idx_q   <= win_idx;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_out_q   <= 1'b0;
            irq_cause_q <= CAUSE_NONE;
            state_q     <= ST_GAP;
          end else if (!granted_live) begin
            irq_out_q   <= 1'b0;
            irq_cause_q <= CAUSE_NONE;
            state_q     <= ST_IDLE;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          irq_out_q   <= 1'b0;
          irq_cause_q <= CAUSE_NONE;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_out   = irq_out_q;
  assign irq_cause = irq_cause_q;

  // Combinational register read; unmapped offsets return zero
  always_comb begin
    bus_rdata = '0;
    case (word_addr)
      ADDR_MTIME_LO:    bus_rdata = mtime_q[31:0];
      ADDR_MTIME_HI:    bus_rdata = mtime_q[63:32];
      ADDR_MTIMECMP_LO: bus_rdata = mtimecmp_q[31:0];
      ADDR_MTIMECMP_HI: bus_rdata = mtimecmp_q[63:32];
      ADDR_MSIP:        bus_rdata[0] = msip_q;
      ADDR_EIE:         bus_rdata[NUM_EXT-1:0] = eie_q;
      ADDR_EIP:         bus_rdata[NUM_EXT-1:0] = eip_q;
      default:          ;
    endcase
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb/tb_irq_source_ctrl.sv - self-checking bench for irq_source_ctrl
module tb_irq_source_ctrl;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    bus_addr;
  logic          bus_we;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic [NE-1:0] ext_irq_in;
  logic          irq_out;
  logic [31:0]   irq_cause;
  logic          irq_ack;

  irq_source_ctrl #(.NUM_EXT(NE), .PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .ext_irq_in (ext_irq_in),
    .irq_out    (irq_out),
    .irq_cause  (irq_cause),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural registers plus who is currently being requested
  logic [63:0]   m_mt, m_cmp;
  logic          m_msip;
  logic [NE-1:0] m_eie, m_eip;
  int            m_phase;     // 0 waiting, 1 requesting, 2 post-ack gap
  logic          m_out;
  logic [31:0]   m_cause;
  int            m_idx;
  logic [NE-1:0] h0, h1, h2, h3;  // ext_irq_in sampled at this and the previous three edges

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a & 5'h1C)
      5'h00:   return m_mt[31:0];
      5'h04:   return m_mt[63:32];
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return {31'd0, m_msip};
      5'h14:   return {28'd0, m_eie};
      5'h18:   return {28'd0, m_eip};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_mt = 64'd0; m_cmp = '1; m_msip = 1'b0; m_eie = '0; m_eip = '0;
    m_phase = 0; m_out = 1'b0; m_cause = 32'd0; m_idx = 0;
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle
  task automatic m_step();
    logic [NE-1:0] act, rise, clr, w1c;
    logic          timer_due, live;
    logic [31:0]   want;
    logic [63:0]   nmt;
    int            win;
    h3 = h2; h2 = h1; h1 = h0; h0 = ext_irq_in;
    rise = h2 & ~h3;
    timer_due = (m_mt >= m_cmp);
    act = m_eip & m_eie;
    win = 0;
    for (int i = NE - 1; i >= 0; i--) if (act[i]) win = i;
    want = (act != 0) ? 32'h8000_000B : m_msip ? 32'h8000_0003 : timer_due ? 32'h8000_0007 : 32'd0;
    clr = '0;
    if (m_phase == 0) begin
      if (want != 0) begin m_out = 1'b1; m_cause = want; m_idx = win; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (m_cause == 32'h8000_000B) live = m_eip[m_idx] & m_eie[m_idx];
      else if (m_cause == 32'h8000_0003) live = m_msip;
      else live = timer_due;
      if (irq_ack) begin
        if (m_cause == 32'h8000_000B) clr[m_idx] = 1'b1;
        m_out = 1'b0; m_cause = 32'd0; m_phase = 2;
      end else if (!live) begin
        m_out = 1'b0; m_cause = 32'd0; m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
    w1c = '0;
    nmt = m_mt + 64'd1;
    if (bus_we) begin
      case (bus_addr & 5'h1C)
        5'h00: nmt = {m_mt[63:32], bus_wdata};
        5'h04: nmt = {bus_wdata, m_mt[31:0]};
        5'h08: m_cmp[31:0] = bus_wdata;
        5'h0C: m_cmp[63:32] = bus_wdata;
        5'h10: m_msip = bus_wdata[0];
        5'h14: m_eie = bus_wdata[NE-1:0];
        5'h18: w1c = bus_wdata[NE-1:0];
        default: ;
      endcase
    end
    m_mt = nmt;
    m_eip = (m_eip & ~w1c & ~clr) | rise;
  endtask

  // One clock: model step, compare request outputs after the edge, return at negedge
  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    chk("irq_out", {63'd0, irq_out}, {63'd0, m_out});
    chk("irq_cause", {32'd0, irq_cause}, {32'd0, m_cause});
    @(negedge clk);
    bus_we = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    cyc();
  endtask

  task automatic rd(input logic [4:0] a, input string tag);
    bus_addr = a; bus_we = 1'b0;
    #1;
    chk(tag, {32'd0, bus_rdata}, {32'd0, m_read(a)});
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (irq_out !== 1'b1 && n < budget) begin cyc(); n++; end
    chk(tag, {63'd0, irq_out}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int op;
    rst = 1'b1; bus_addr = '0; bus_we = 1'b0; bus_wdata = '0; ext_irq_in = '0; irq_ack = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);

    // Reset state of every register
    for (int a = 0; a < 32; a += 4) rd(5'(a), "reset_read");
    chk("reset_irq_out", {63'd0, irq_out}, 64'd0);
    chk("reset_mtimecmp_hi", {32'd0, m_read(5'h0C)}, 64'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    // Timer compare, ack, re-request, then cleared by rewriting mtimecmp
    wr(5'h08, 32'd20);
    wr(5'h0C, 32'd0);
    wait_irq("mti_req", 60);
    chk("mti_cause", {32'd0, irq_cause}, 64'h8000_0007);
    rd(5'h00, "mtime_at_mti");
    irq_ack = 1'b1;
    cyc();
    chk("mti_gap", {63'd0, irq_out}, 64'd0);
    wait_irq("mti_rereq", 4);
    wr(5'h08, 32'hFFFF_FFFF);
    cyc();
    chk("mti_cleared", {63'd0, irq_out}, 64'd0);
    repeat (5) cyc();
    chk("mti_no_rereq", {63'd0, irq_out}, 64'd0);

    // Two external edges in one cycle, serviced lowest index first
    wr(5'h14, 32'h5);
    ext_irq_in = 4'b0101;
    cyc();
    ext_irq_in = 4'b0000;
    cyc();
    cyc();
    chk("mei_latency_2", {63'd0, irq_out}, 64'd0);
    cyc();
    chk("mei_latency_3", {63'd0, irq_out}, 64'd1);
    chk("mei_cause", {32'd0, irq_cause}, 64'h8000_000B);
    rd(5'h18, "eip_both");
    chk("eip_5", {32'd0, bus_rdata}, 64'h5);
    irq_ack = 1'b1;
    cyc();
    rd(5'h18, "eip_after_ack0");
    chk("eip_4", {32'd0, bus_rdata}, 64'h4);
    wait_irq("mei_req2", 4);
    chk("mei_cause2", {32'd0, irq_cause}, 64'h8000_000B);
    irq_ack = 1'b1;
    cyc();
    rd(5'h18, "eip_after_ack2");
    chk("eip_0", {32'd0, bus_rdata}, 64'h0);

    // MSI and MTI become pending on the same edge: MSI goes first
    v = m_mt[31:0] + 32'd2;
    wr(5'h08, v);
    wr(5'h10, 32'h1);
    cyc();
    chk("msi_first", {32'd0, irq_cause}, 64'h8000_0003);
    wr(5'h10, 32'h0);
    cyc();
    chk("msi_drop", {63'd0, irq_out}, 64'd0);
    wait_irq("mti_after_msi", 4);
    chk("mti_after_msi_cause", {32'd0, irq_cause}, 64'h8000_0007);
    irq_ack = 1'b1;
    cyc();
    wr(5'h0C, 32'hFFFF_FFFF);
    repeat (3) cyc();
    chk("quiet_after_cmp_hi", {63'd0, irq_out}, 64'd0);

    // mtime carry into the high half, and write-over-tick
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'h0);
    cyc();
    rd(5'h04, "carry_hi");
    chk("carry_hi_1", {32'd0, bus_rdata}, 64'h1);
    rd(5'h00, "carry_lo");
    chk("carry_lo_0", {32'd0, bus_rdata}, 64'h0);
    v = $urandom;
    wr(5'h00, v);
    rd(5'h00, "write_beats_tick");
    chk("write_beats_tick_val", {32'd0, bus_rdata}, {32'd0, v});

    // Randomized soak against the model
    for (int n = 0; n < 400; n++) begin
      rd(5'($urandom_range(0, 31)), "soak_read");
      ext_irq_in = NE'($urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 5);
        bus_we = 1'b1;
        case (op)
          0: begin bus_addr = 5'h10; bus_wdata = $urandom; end
          1: begin bus_addr = 5'h14; bus_wdata = $urandom; end
          2: begin bus_addr = 5'h18; bus_wdata = $urandom; end
          3: begin bus_addr = 5'h08; bus_wdata = $urandom; end
          4: begin bus_addr = 5'h0C; bus_wdata = $urandom_range(0, 2); end
          default: begin bus_addr = 5'h00; bus_wdata = $urandom; end
        endcase
        bus_addr = bus_addr | 5'($urandom_range(0, 3));
      end
      cyc();
    end

    // Asynchronous reset while a request is outstanding
    ext_irq_in = '0;
    irq_ack = 1'b0;
    wr(5'h10, 32'h1);
    wait_irq("pre_reset_req", 8);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_irq_out", {63'd0, irq_out}, 64'd0);
    chk("rst_irq_cause", {32'd0, irq_cause}, 64'd0);
    m_reset();
    rd(5'h18, "rst_eip");
    rd(5'h00, "rst_mtime_lo");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc();
    rd(5'h00, "post_rst_mtime");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
